// File: rtl/vga_timing_640_480_pkg.sv
// Shared constants and phase encoding for the 640x480@60 raster timing generator.
// Default porch/sync/active figures plus the per-axis totals derived from them.
package vga_timing_640_480_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HIDX_W = 10;
  localparam int VIDX_W = 9;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_timing_640_480_axis_timer.sv
// One raster axis: four-phase FSM (active, front porch, sync, back porch) with a
// per-phase counter and a position counter. Exposes next-state decodes for registering.
module vga_axis_timer
  import vga_timing_640_480_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int POS_W  = HIDX_W
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             en,
  output logic             wrap,
  output logic [POS_W-1:0] pos_nxt,
  output logic             active_nxt,
  output logic             sync_nxt
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  phase_t           phase;
  phase_t           phase_nxt;
  logic [POS_W-1:0] cnt;
  logic [POS_W-1:0] cnt_nxt;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] len_m1;
  logic             last;

  always_comb begin
    len_m1 = POS_W'(BP - 1);
    unique case (phase)
      PH_ACT:  len_m1 = POS_W'(ACTIVE - 1);
      PH_FP:   len_m1 = POS_W'(FP - 1);
      PH_SYNC: len_m1 = POS_W'(SYNC - 1);
      PH_BP:   len_m1 = POS_W'(BP - 1);
    endcase
  end

  assign last = (cnt == len_m1);
  assign wrap = en && (phase == PH_BP) && last;

  // Phase order wraps BP -> ACT through the 2-bit encoding.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt;
    pos_nxt   = pos;
    if (en) begin
      if (last) begin
        phase_nxt = phase_t'(phase + 2'd1);
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + POS_W'(1);
      end
      pos_nxt = wrap ? '0 : pos + POS_W'(1);
    end
  end

  assign active_nxt = (phase_nxt == PH_ACT);
  assign sync_nxt   = (phase_nxt == PH_SYNC);

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      phase <= PH_BP;
      cnt   <= POS_W'(BP - 1);
      pos   <= POS_W'(TOTAL - 1);
    end else begin
      phase <= phase_nxt;
      cnt   <= cnt_nxt;
      pos   <= pos_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_640_480.sv
// 640x480@60 raster timing generator: cascaded horizontal/vertical axis timers,
// stepping one pixel per i_px_clk strobe, with all outputs registered.
module vga_timing_640_480
  import vga_timing_640_480_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              i_sclr_n,
  input  logic              i_px_clk,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_haddr_en,
  output logic              o_vaddr_en,
  output logic [HIDX_W-1:0] o_hidx,
  output logic [VIDX_W-1:0] o_vidx,
  output logic              o_line_start,
  output logic              o_frame_start
);

  logic              h_wrap;
  logic              v_wrap;
  logic              h_act;
  logic              v_act;
  logic              h_sync;
  logic              v_sync;
  logic [HIDX_W-1:0] h_pos;
  logic [VIDX_W-1:0] v_pos;

  vga_axis_timer #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POS_W  (HIDX_W)
  ) u_h_axis (
    .clk        (clk),
    .sclr_n     (i_sclr_n),
    .en         (i_px_clk),
    .wrap       (h_wrap),
    .pos_nxt    (h_pos),
    .active_nxt (h_act),
    .sync_nxt   (h_sync)
  );

  // The vertical axis steps once per line, on the strobe that wraps the horizontal axis.
  vga_axis_timer #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POS_W  (VIDX_W)
  ) u_v_axis (
    .clk        (clk),
    .sclr_n     (i_sclr_n),
    .en         (h_wrap),
    .wrap       (v_wrap),
    .pos_nxt    (v_pos),
    .active_nxt (v_act),
    .sync_nxt   (v_sync)
  );

  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      o_hsync       <= !SYNC_POL;
      o_vsync       <= !SYNC_POL;
      o_haddr_en    <= 1'b0;
      o_vaddr_en    <= 1'b0;
      o_hidx        <= '0;
      o_vidx        <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_px_clk) begin
      o_hsync       <= h_sync ? SYNC_POL : !SYNC_POL;
      o_vsync       <= v_sync ? SYNC_POL : !SYNC_POL;
      o_haddr_en    <= h_act;
      o_vaddr_en    <= v_act;
      o_hidx        <= h_act ? h_pos : '0;
      o_vidx        <= v_act ? v_pos : '0;
      o_line_start  <= h_wrap;
      o_frame_start <= h_wrap && v_wrap;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Bench for vga_timing_640_480: a default 640x480 instance plus a shrunken-raster
// instance (active-high sync) driven in lockstep and checked against a position model.
module tb_vga_timing_640_480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sclr_n;
  logic px;

  logic       b_hsync, b_vsync, b_haddr_en, b_vaddr_en, b_line_start, b_frame_start;
  logic [9:0] b_hidx;
  logic [8:0] b_vidx;
  logic       s_hsync, s_vsync, s_haddr_en, s_vaddr_en, s_line_start, s_frame_start;
  logic [9:0] s_hidx;
  logic [8:0] s_vidx;

  vga_timing_640_480 dut_big (
    .clk           (clk),
    .i_sclr_n      (sclr_n),
    .i_px_clk      (px),
    .o_hsync       (b_hsync),
    .o_vsync       (b_vsync),
    .o_haddr_en    (b_haddr_en),
    .o_vaddr_en    (b_vaddr_en),
    .o_hidx        (b_hidx),
    .o_vidx        (b_vidx),
    .o_line_start  (b_line_start),
    .o_frame_start (b_frame_start)
  );

  vga_timing_640_480 #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b1)
  ) dut_small (
    .clk           (clk),
    .i_sclr_n      (sclr_n),
    .i_px_clk      (px),
    .o_hsync       (s_hsync),
    .o_vsync       (s_vsync),
    .o_haddr_en    (s_haddr_en),
    .o_vaddr_en    (s_vaddr_en),
    .o_hidx        (s_hidx),
    .o_vidx        (s_vidx),
    .o_line_start  (s_line_start),
    .o_frame_start (s_frame_start)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       ha;
    logic       va;
    logic [9:0] hi;
    logic [8:0] vi;
    logic       ls;
    logic       fs;
  } exp_t;

  localparam int HA [2] = '{640, 16};
  localparam int HF [2] = '{16, 2};
  localparam int HS [2] = '{96, 3};
  localparam int HB [2] = '{48, 3};
  localparam int VA [2] = '{480, 12};
  localparam int VF [2] = '{10, 2};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 3};
  localparam bit POL [2] = '{1'b0, 1'b1};

  localparam logic [24:0] RST_B = {2'b11, 23'd0};
  localparam logic [24:0] RST_S = 25'd0;

  logic [24:0] bvec, svec;
  assign bvec = {b_hsync, b_vsync, b_haddr_en, b_vaddr_en, b_hidx, b_vidx, b_line_start, b_frame_start};
  assign svec = {s_hsync, s_vsync, s_haddr_en, s_vaddr_en, s_hidx, s_vidx, s_line_start, s_frame_start};

  int   total = 0;
  int   bad   = 0;
  int   hm [2];
  int   vm [2];
  exp_t cur [2];
  exp_t qb [$];
  exp_t qs [$];

  function automatic exp_t dec(int i, int h, int v, logic ls, logic fs);
    exp_t e;
    e.hs = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? POL[i] : ~POL[i];
    e.vs = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? POL[i] : ~POL[i];
    e.ha = (h < HA[i]);
    e.va = (v < VA[i]);
    e.hi = e.ha ? 10'(h) : 10'd0;
    e.vi = e.va ? 9'(v) : 9'd0;
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  // Drive one clock of stimulus, advance the model, queue what each DUT must show.
  task automatic cyc(input logic p, input logic r);
    px     = p;
    sclr_n = r;
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        hm[i]  = HA[i] + HF[i] + HS[i] + HB[i] - 1;
        vm[i]  = VA[i] + VF[i] + VS[i] + VB[i] - 1;
        cur[i] = dec(i, hm[i], vm[i], 1'b0, 1'b0);
      end else if (p) begin
        hm[i]++;
        if (hm[i] == HA[i] + HF[i] + HS[i] + HB[i]) begin
          hm[i] = 0;
          vm[i]++;
          if (vm[i] == VA[i] + VF[i] + VS[i] + VB[i]) vm[i] = 0;
        end
        cur[i] = dec(i, hm[i], vm[i], hm[i] == 0, hm[i] == 0 && vm[i] == 0);
      end else begin
        cur[i].ls = 1'b0;
        cur[i].fs = 1'b0;
      end
    end
    qb.push_back(cur[0]);
    qs.push_back(cur[1]);
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      total++;
      if (bvec !== e) begin
        bad++;
        $display("FAIL sb_big t=%0t got=%h want=%h", $time, bvec, e);
      end
    end
    if (qs.size() > 0) begin
      e = qs.pop_front();
      total++;
      if (svec !== e) begin
        bad++;
        $display("FAIL sb_small t=%0t got=%h want=%h", $time, svec, e);
      end
    end
  end

  task automatic test_reset;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    total++;
    if (bvec !== RST_B) begin bad++; $display("FAIL reset_big got=%h want=%h", bvec, RST_B); end
    total++;
    if (svec !== RST_S) begin bad++; $display("FAIL reset_small got=%h want=%h", svec, RST_S); end
    cyc(1'b0, 1'b1);
    total++;
    if (bvec !== RST_B) begin bad++; $display("FAIL reset_hold got=%h want=%h", bvec, RST_B); end
    cyc(1'b1, 1'b1);
    total++;
    if ({b_haddr_en, b_vaddr_en, b_hidx, b_vidx, b_line_start, b_frame_start, b_hsync, b_vsync}
        !== {2'b11, 10'd0, 9'd0, 4'b1111}) begin
      bad++;
      $display("FAIL first_strobe got ha=%b va=%b hi=%0d vi=%0d ls=%b fs=%b hs=%b vs=%b want 1 1 0 0 1 1 1 1",
               b_haddr_en, b_vaddr_en, b_hidx, b_vidx, b_line_start, b_frame_start, b_hsync, b_vsync);
    end
    cyc(1'b0, 1'b1);
    total++;
    if ({b_line_start, b_frame_start} !== 2'b00) begin
      bad++;
      $display("FAIL pulse_width got ls=%b fs=%b want 0 0", b_line_start, b_frame_start);
    end
  endtask

  task automatic test_hline;
    int         first_fall = -1;
    int         low_cnt    = 0;
    int         first_low  = -1;
    logic       ls800      = 1'b0;
    logic [8:0] vidx800    = '0;
    logic [9:0] hidx800    = '1;
    logic       quiet      = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    for (int s = 1; s <= 800; s++) begin
      cyc(1'b1, 1'b1);
      if (!b_haddr_en && first_fall < 0) first_fall = s;
      if (!b_hsync) begin
        low_cnt++;
        if (first_low < 0) first_low = s;
      end
      if (s == 800) begin
        ls800   = b_line_start;
        vidx800 = b_vidx;
        hidx800 = b_hidx;
      end else if (b_line_start || b_frame_start) begin
        quiet = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 1'b1);
        if (b_line_start || b_frame_start) quiet = 1'b0;
      end
    end
    total++;
    if (first_fall !== 640) begin bad++; $display("FAIL haddr_fall got=%0d want=640", first_fall); end
    total++;
    if (low_cnt !== 96) begin bad++; $display("FAIL hsync_width got=%0d want=96", low_cnt); end
    total++;
    if (first_low !== 656) begin bad++; $display("FAIL hsync_start got=%0d want=656", first_low); end
    total++;
    if ({ls800, vidx800, hidx800} !== {1'b1, 9'd1, 10'd0}) begin
      bad++;
      $display("FAIL line_wrap got ls=%b vidx=%0d hidx=%0d want ls=1 vidx=1 hidx=0", ls800, vidx800, hidx800);
    end
    total++;
    if (quiet !== 1'b1) begin bad++; $display("FAIL stray_pulse got=%b want=1", quiet); end
  endtask

  task automatic test_freeze;
    logic [24:0] snap;
    logic        held = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (300) cyc(1'b1, 1'b1);
    total++;
    if ({b_haddr_en, b_hidx} !== {1'b1, 10'd300}) begin
      bad++;
      $display("FAIL freeze_pos got ha=%b hidx=%0d want ha=1 hidx=300", b_haddr_en, b_hidx);
    end
    snap = bvec;
    repeat (50) begin
      cyc(1'b0, 1'b1);
      if (bvec !== snap || b_line_start || b_frame_start) held = 1'b0;
    end
    total++;
    if (held !== 1'b1 || b_hidx !== 10'd300) begin
      bad++;
      $display("FAIL freeze_hold got held=%b hidx=%0d want held=1 hidx=300", held, b_hidx);
    end
  endtask

  task automatic test_midreset;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (178) cyc(1'b1, 1'b1);
    total++;
    if ({s_hidx, s_vidx} !== {10'd10, 9'd7}) begin
      bad++;
      $display("FAIL midreset_pos got hidx=%0d vidx=%0d want 10 7", s_hidx, s_vidx);
    end
    cyc(1'b1, 1'b0);
    total++;
    if (bvec !== RST_B) begin bad++; $display("FAIL midreset_big got=%h want=%h", bvec, RST_B); end
    total++;
    if (svec !== RST_S) begin bad++; $display("FAIL midreset_small got=%h want=%h", svec, RST_S); end
    cyc(1'b1, 1'b1);
    total++;
    if ({b_frame_start, b_line_start, b_haddr_en, b_vaddr_en, b_hidx, b_vidx, s_frame_start}
        !== {4'b1111, 10'd0, 9'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_restart got fs=%b ls=%b hi=%0d vi=%0d sfs=%b want fs=1 ls=1 hi=0 vi=0 sfs=1",
               b_frame_start, b_line_start, b_hidx, b_vidx, s_frame_start);
    end
  endtask

  task automatic test_frame;
    int   fall      = -1;
    int   vs_cnt    = 0;
    int   vs_first  = -1;
    int   vs_hidx   = -1;
    int   next_fs   = -1;
    int   rises     = 0;
    logic blank_ok  = 1'b1;
    logic prev_va;
    logic prev_hs;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    prev_va = s_vaddr_en;
    prev_hs = s_hsync;
    for (int k = 1; k <= 1000; k++) begin
      cyc(1'b1, 1'b1);
      if (prev_va && !s_vaddr_en && fall < 0) fall = k;
      if (s_vsync) begin
        vs_cnt++;
        if (vs_first < 0) begin
          vs_first = k;
          vs_hidx  = s_haddr_en ? int'(s_hidx) : -1;
        end
      end
      if (!prev_hs && s_hsync && !s_vaddr_en) rises++;
      if ((!s_haddr_en && s_hidx != 10'd0) || (!s_vaddr_en && s_vidx != 9'd0)) blank_ok = 1'b0;
      prev_va = s_vaddr_en;
      prev_hs = s_hsync;
      if (s_frame_start) begin
        next_fs = k;
        break;
      end
    end
    total++;
    if (fall !== 288) begin bad++; $display("FAIL vaddr_fall got=%0d want=288", fall); end
    total++;
    if (vs_cnt !== 48) begin bad++; $display("FAIL vsync_width got=%0d want=48", vs_cnt); end
    total++;
    if ({vs_first, vs_hidx} !== {32'sd336, 32'sd0}) begin
      bad++;
      $display("FAIL vsync_start got clk=%0d hidx=%0d want clk=336 hidx=0", vs_first, vs_hidx);
    end
    total++;
    if (next_fs !== 456) begin bad++; $display("FAIL frame_period got=%0d want=456", next_fs); end
    total++;
    if (rises !== 7) begin bad++; $display("FAIL vblank_hsync got=%0d want=7", rises); end
    total++;
    if (blank_ok !== 1'b1) begin bad++; $display("FAIL frame_blank_idx got=%b want=1", blank_ok); end
  endtask

  task automatic test_blanking;
    logic ok = 1'b1;
    logic p;
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      p = 1'($urandom_range(0, 1));
      cyc(p, 1'b1);
      if (!b_haddr_en && b_hidx != 10'd0) ok = 1'b0;
      if (!b_vaddr_en && b_vidx != 9'd0)  ok = 1'b0;
      if (!s_haddr_en && s_hidx != 10'd0) ok = 1'b0;
      if (!s_vaddr_en && s_vidx != 9'd0)  ok = 1'b0;
      if (!p && (b_line_start || b_frame_start || s_line_start || s_frame_start)) ok = 1'b0;
    end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL random_blanking got=%b want=1", ok); end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_freeze();
    test_midreset();
    test_frame();
    test_blanking();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
